// File: rtl/bcd_display_scan_if.sv
// ----------------------------------------------------------------------------
// bcd_display_scan_if
//   Bundles the data and display signals of bcd_display_scan.
//   master : the side that supplies BCD values and reads the display pins
//   slave  : the display scanner itself
// Signals
//   load        capture bcd_in into the pending register
//   bcd_in      packed BCD digits, [3:0] = digit 0 (least significant)
//   blank_lz    1: blank leading-zero digits
//   seg         segment bus {g,f,e,d,c,b,a}
//   an          one-hot digit enables
//   frame_done  one-cycle pulse when the scan wraps to digit 0
//   err         committed value holds a digit > 9
// ----------------------------------------------------------------------------
interface bcd_display_scan_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;
    logic                    err;

    modport master (
        output load, bcd_in, blank_lz,
        input  seg, an, frame_done, err
    );

    modport slave (
        input  load, bcd_in, blank_lz,
        output seg, an, frame_done, err
    );
endinterface

// File: rtl/bcd_display_scan.sv
// ----------------------------------------------------------------------------
// bcd_display_scan
//   Time-multiplexed 7-segment display driver. A packed multi-digit BCD word
//   is captured into a pending register and committed to the display register
//   only at a frame boundary, so a frame never shows a mix of old and new
//   digits. One digit is scanned per slot of REFRESH_DIV clocks; the first
//   BLANK_CYCLES clocks of every slot keep all anodes off to avoid ghosting.
//   Leading zeros may be blanked; digits > 9 show '-' and raise err.
// Ports
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport of bcd_display_scan_if:
//         load, bcd_in, blank_lz in; seg, an, frame_done, err out
//   seg/an/frame_done are registered and reflect the scan state of the
//   previous cycle.
// ----------------------------------------------------------------------------
module bcd_display_scan #(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          AN_ACT_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    bcd_display_scan_if.slave   bus
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_OFF = {7{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACT_LOW}};

    // Active-high gfedcba pattern for one BCD digit; 10..15 show '-'.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          tc;
    logic          last_digit;
    logic          frame_edge;

    assign tc         = (cnt == CW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign frame_edge = tc && last_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= last_digit ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending / display registers
    // ------------------------------------------------------------------
    logic [DW-1:0] pending;
    logic          pend_vld;
    logic [DW-1:0] display;
    logic          err_q;
    logic          pend_err;

    always_comb begin
        pend_err = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (pending[4*k +: 4] > 4'd9) begin
                pend_err = 1'b1;
            end
        end
    end

    // A load on the frame-edge cycle writes pending while the commit reads
    // the old pending value, so the new load keeps pend_vld set and is
    // committed at the following frame edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_vld <= 1'b0;
            display  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (frame_edge && pend_vld) begin
                display <= pending;
                err_q   <= pend_err;
            end
            if (bus.load) begin
                pending  <= bus.bcd_in;
                pend_vld <= 1'b1;
            end else if (frame_edge) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit selection, leading-zero blanking and output decode
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic                  in_gap;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [6:0]            seg_hi;

    // Walk from the most significant digit down: a digit is blanked while
    // every digit above and including it is zero. Digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            zero_run = zero_run && (display[4*(k-1) +: 4] == 4'd0);
            if (k > 1) begin
                lz_blank[k-1] = bus.blank_lz && zero_run;
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_digit = display[4*k +: 4];
                cur_blank = lz_blank[k];
            end
        end
    end

    assign in_gap = (32'(cnt) < BLANK_CYCLES);
    assign lit    = !in_gap && !cur_blank;

    always_comb begin
        an_hi = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            an_hi[k] = lit && (idx == IW'(k));
        end
    end

    assign seg_hi = lit ? seg_encode(cur_digit) : 7'b0000000;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  edge_q;
    logic                  fd_q;

    // edge_q marks the cycle the scan sits at digit 0 / count 0; delaying it
    // once more lines frame_done up with the registered an-off cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
            edge_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            seg_q  <= seg_hi ^ SEG_OFF;
            an_q   <= an_hi ^ AN_OFF;
            edge_q <= frame_edge;
            fd_q   <= edge_q;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// ----------------------------------------------------------------------------
// tb_bcd_display_scan
//   NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1, active-low seg and an.
//   A frame is 8 cycles; frame_done marks output phase 0. Expected digit
//   slot contents are queued by the stimulus side and checked by a monitor
//   at output phases 1..3 (digit 0) and 5..7 (digit 1).
// ----------------------------------------------------------------------------
module tb_bcd_display_scan;

    logic clk;
    logic rst;

    bcd_display_scan_if #(.NUM_DIGITS(2)) dif ();

    bcd_display_scan #(
        .NUM_DIGITS  (2),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] bcd;
        logic       lz;
        logic [6:0] s0;
        logic [1:0] a0;
        logic [6:0] s1;
        logic [1:0] a1;
        logic       err;
    } vec_t;

    exp_t sb[$];
    vec_t vec[11];

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int mon_phase = 0;
    bit mon_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [6:0] s, input logic [1:0] a, input logic e);
        exp_t x;
        x.seg = s;
        x.an  = a;
        x.err = e;
        sb.push_back(x);
    endtask

    // Both slots of one frame showing a two-digit value, blank_lz=0.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic e);
        push(s0, 2'b10, e);
        push(s1, 2'b01, e);
    endtask

    task automatic wait_frames(input int n);
        int tgt;
        tgt = frames + n;
        for (int i = 0; i < 20 * n; i++) begin
            @(negedge clk);
            if (frames >= tgt) return;
        end
        chk("frame_timeout", 32'(frames), 32'(tgt));
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mon_valid && mon_phase == p) return;
        end
        chk("phase_timeout", 32'(mon_phase), 32'(p));
    endtask

    // Drives load for one cycle starting now (caller is at a negedge).
    task automatic do_load(input logic [7:0] v);
        dif.bcd_in = v;
        dif.load   = 1'b1;
        @(negedge clk);
        dif.load   = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        int since;
        exp_t e;
        since = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_valid = 1'b0;
                since = 0;
                continue;
            end
            since++;
            if (dif.frame_done) begin
                if (mon_valid) chk("frame_period", 32'(since), 32'd8);
                since     = 0;
                mon_valid = 1'b1;
                mon_phase = 0;
                frames++;
            end else begin
                mon_phase = (mon_phase + 1) % 8;
            end
            if (mon_valid) begin
                chk("an_onehot", 32'($countones(~dif.an) <= 1), 32'd1);
                if (mon_phase == 0 || mon_phase == 4) begin
                    chk("slot_gap", 32'({dif.seg, dif.an}), 32'({7'h7F, 2'b11}));
                end else if (sb.size() > 0) begin
                    e = sb[0];
                    chk($sformatf("slot_ph%0d", mon_phase),
                        32'({dif.seg, dif.an, dif.err}), 32'({e.seg, e.an, e.err}));
                    if (mon_phase == 3 || mon_phase == 7) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // seg codes (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02
        // 7=78 8=00 9=10 '-'=3F off=7F
        vec[0]  = '{8'h13, 1'b0, 7'h30, 2'b10, 7'h79, 2'b01, 1'b0};
        vec[1]  = '{8'h07, 1'b1, 7'h78, 2'b10, 7'h7F, 2'b11, 1'b0};
        vec[2]  = '{8'h00, 1'b1, 7'h40, 2'b10, 7'h7F, 2'b11, 1'b0};
        vec[3]  = '{8'h00, 1'b0, 7'h40, 2'b10, 7'h40, 2'b01, 1'b0};
        vec[4]  = '{8'h1A, 1'b0, 7'h3F, 2'b10, 7'h79, 2'b01, 1'b1};
        vec[5]  = '{8'h12, 1'b0, 7'h24, 2'b10, 7'h79, 2'b01, 1'b0};
        vec[6]  = '{8'hA0, 1'b1, 7'h40, 2'b10, 7'h3F, 2'b01, 1'b1};
        vec[7]  = '{8'h98, 1'b1, 7'h00, 2'b10, 7'h10, 2'b01, 1'b0};
        vec[8]  = '{8'h05, 1'b0, 7'h12, 2'b10, 7'h40, 2'b01, 1'b0};
        vec[9]  = '{8'h06, 1'b1, 7'h02, 2'b10, 7'h7F, 2'b11, 1'b0};
        vec[10] = '{8'hF4, 1'b1, 7'h19, 2'b10, 7'h3F, 2'b01, 1'b1};

        rst          = 1'b1;
        dif.load     = 1'b0;
        dif.bcd_in   = '0;
        dif.blank_lz = 1'b0;
        #3;
        chk("reset_out", 32'({dif.seg, dif.an, dif.err, dif.frame_done}),
            32'({7'h7F, 2'b11, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven values
        for (int i = 0; i < 11; i++) begin
            dif.blank_lz = vec[i].lz;
            do_load(vec[i].bcd);
            wait_frames(2);
            push(vec[i].s0, vec[i].a0, vec[i].err);
            push(vec[i].s1, vec[i].a1, vec[i].err);
            wait_frames(1);
        end

        // Asynchronous reset in the middle of a lit digit slot, err=1
        wait_phase(2);
        sb.delete();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_slot", 32'({dif.seg, dif.an, dif.err, dif.frame_done}),
            32'({7'h7F, 2'b11, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        // display cleared to 0, blank_lz still 1: digit 1 blanked
        wait_frames(2);
        push(7'h40, 2'b10, 1'b0);
        push(7'h7F, 2'b11, 1'b0);
        wait_frames(1);

        // Tear-free update and frame-edge load deferral
        dif.blank_lz = 1'b0;
        do_load(8'h13);
        wait_frames(2);
        push_frame(7'h30, 7'h79, 1'b0);   // this frame: still 13
        push_frame(7'h12, 7'h24, 1'b0);   // next frame: 25
        wait_phase(1);
        do_load(8'h25);                   // mid-frame, digit 0 slot
        wait_frames(1);
        push_frame(7'h12, 7'h24, 1'b0);   // 25 again: edge load deferred
        push_frame(7'h78, 7'h19, 1'b0);   // then 47
        wait_phase(6);
        do_load(8'h47);                   // sampled on the frame-edge clock
        wait_frames(3);

        wait_frames(1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
